// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester and SRAM signal bundle for sram_port_arbiter
//
// Purpose: groups the two requester ports, the shared read-data return and the
// SRAM-side access bus into one interface.
// Ports (modport slave = arbiter view, master = requester/SRAM environment view):
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1  requester commands
//   gnt0/gnt1, rvalid0/rvalid1, rdata, owner         arbiter responses
//   mem_en, mem_we, mem_addr, mem_wdata              SRAM access strobe and command
//   mem_rdata                                        SRAM read data (one cycle after a read)
interface sram_port_arbiter_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8
);
  logic                 req0, req1;
  logic                 we0, we1;
  logic [ADDR_SIZE-1:0] addr0, addr1;
  logic [WORD_SIZE-1:0] wdata0, wdata1;
  logic                 gnt0, gnt1;
  logic                 rvalid0, rvalid1;
  logic [WORD_SIZE-1:0] rdata;
  logic                 owner;
  logic                 mem_en, mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, owner,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, owner,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port round-robin arbiter with burst cap for a single-port SRAM
//
// Purpose: shares one single-port SRAM between the CPU (port 0) and the
// loader/debug master (port 1). One access per clock, round-robin with a cap of
// MAX_BURST consecutive grants while the other port waits, read data routed back
// to the port that issued the read.
// Ports:
//   clk   system clock, all state changes on posedge
//   rst   synchronous active-low reset
//   bus   sram_port_arbiter_if.slave: requester commands in, gnt/rvalid/rdata/owner
//         out, SRAM access bus out, mem_rdata in
module sram_port_arbiter #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           state;
  logic             owner_q;
  logic [CNT_W-1:0] burst_cnt;
  logic             rvalid0_q, rvalid1_q;
  logic             gnt0, gnt1, any_gnt;

  // Grant decision. Under contention the owner keeps the bus only while it held
  // it last cycle and has not used up its burst; otherwise the other port wins,
  // which also covers the owner dropping its request (no idle bubble).
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (bus.req0 && bus.req1) begin
        if (state == ST_BUSY && burst_cnt < CAP) begin
          gnt0 = ~owner_q;
          gnt1 = owner_q;
        end else begin
          gnt0 = owner_q;
          gnt1 = ~owner_q;
        end
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner_q   <= 1'b1;
      burst_cnt <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 & ~bus.we0;
      rvalid1_q <= gnt1 & ~bus.we1;
      if (!any_gnt) begin
        state     <= ST_IDLE;
        burst_cnt <= '0;
      end else begin
        state   <= ST_BUSY;
        owner_q <= gnt1;
        if (state == ST_BUSY && gnt1 == owner_q) begin
          if (burst_cnt != CAP) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= CNT_W'(1);
        end
      end
    end
  end

  // rvalid is masked while reset is held so a read granted just before reset
  // never reports data to its requester.
  assign bus.rvalid0 = rvalid0_q & rst;
  assign bus.rvalid1 = rvalid1_q & rst;
  assign bus.rdata   = bus.mem_rdata;
  assign bus.owner   = owner_q;
  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;

  assign bus.mem_en    = any_gnt;
  assign bus.mem_we    = (gnt0 & bus.we0) | (gnt1 & bus.we1);
  assign bus.mem_addr  = gnt0 ? bus.addr0 : gnt1 ? bus.addr1 : {ADDR_SIZE{1'b0}};
  assign bus.mem_wdata = gnt0 ? bus.wdata0 : gnt1 ? bus.wdata1 : {WORD_SIZE{1'b0}};
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - testbench for sram_port_arbiter
module tb_sram_port_arbiter;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.WORD_SIZE(8), .ADDR_SIZE(8)) bus ();

  sram_port_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .MAX_BURST(MAX_BURST), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Behavioural single-port SRAM driven by the arbiter's memory bus.
  logic [7:0] sram [256];
  logic [7:0] sram_q;
  logic       load_mem;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) sram[i] <= 8'(i * 3 + 1);
    end else if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            sram_q <= sram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = sram_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Grant history (one entry per cycle, -1 = idle); owner = last granted port.
  int         hist[$];
  int         m_own = 1;
  logic [7:0] ref_mem [256];
  bit         pend0, pend1;
  logic [7:0] pdata;
  int         mg;

  function automatic int pick(input bit r, input bit q0, input bit q1);
    bit act;
    int streak;
    if (!r || (!q0 && !q1)) return -1;
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    act = (hist.size() > 0) && (hist[hist.size()-1] >= 0);
    streak = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != m_own) break;
      streak++;
    end
    if (act && streak < MAX_BURST) return m_own;
    return 1 - m_own;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      hist.delete();
      m_own = 1;
      pend0 = 0;
      pend1 = 0;
    end else begin
      pend0 = 0;
      pend1 = 0;
      if (mg == 0) begin
        if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
        else begin pend0 = 1; pdata = ref_mem[bus.addr0]; end
      end else if (mg == 1) begin
        if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
        else begin pend1 = 1; pdata = ref_mem[bus.addr1]; end
      end
      hist.push_back(mg);
      if (hist.size() > 8) void'(hist.pop_front());
      if (mg >= 0) m_own = mg;
    end
  endtask

  task automatic advance();
    mg = pick(rst, bus.req0, bus.req1);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit rs; bit q0; bit w0; logic [7:0] a0; logic [7:0] d0;
    bit q1; bit w1; logic [7:0] a1; logic [7:0] d1;
    bit g0; bit g1; bit v0; bit v1; logic [7:0] rd; int bc; int own;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(bit rs, bit q0, bit w0, logic [7:0] a0, logic [7:0] d0,
                              bit q1, bit w1, logic [7:0] a1, logic [7:0] d1,
                              bit g0, bit g1, bit v0, bit v1, logic [7:0] rd, int bc, int own);
    vec_t v;
    v.rs = rs; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd; v.bc = bc; v.own = own;
    return v;
  endfunction

  task automatic drive(bit rs, bit q0, bit w0, logic [7:0] a0, logic [7:0] d0,
                       bit q1, bit w1, logic [7:0] a1, logic [7:0] d1);
    rst = rs;
    bus.req0 = q0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = q1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  bit         p_q [2];
  bit         p_w [2];
  logic [7:0] p_a [2];
  logic [7:0] p_d [2];

  task automatic new_cmd(input int p);
    p_q[p] = ($urandom_range(0, 9) < 7);
    p_w[p] = $urandom_range(0, 2) == 0;
    p_a[p] = 8'($urandom_range(0, 15));
    p_d[p] = 8'($urandom);
  endtask

  initial begin
    int nmis;
    logic [7:0] er;
    load_mem = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 3 + 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rs q0 w0 a0 d0 q1 w1 a1 d1 | g0 g1 v0 v1 rd bc own
    vq.push_back(mk(0,1,0,2,0, 1,0,5,0,      0,0,0,0,0,    -1,-1));
    vq.push_back(mk(0,1,0,2,0, 1,0,5,0,      0,0,0,0,0,     0, 1));
    vq.push_back(mk(0,1,0,2,0, 1,0,5,0,      0,0,0,0,0,     0, 1));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      1,0,0,0,0,     0, 1));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      1,0,1,0,7,     1, 0));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      1,0,1,0,7,     2, 0));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      1,0,1,0,7,     3, 0));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      0,1,1,0,7,     4, 0));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      0,1,0,1,16,    1, 1));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      0,1,0,1,16,    2, 1));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      0,1,0,1,16,    3, 1));
    vq.push_back(mk(1,1,0,2,0, 1,0,5,0,      1,0,0,1,16,    4, 1));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,      0,0,1,0,7,     1, 0));
    vq.push_back(mk(1,0,0,0,0, 1,1,139,8'hF0, 0,1,0,0,0,    0, 0));
    vq.push_back(mk(1,1,0,139,0, 0,0,0,0,    1,0,0,0,0,     1, 1));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,      0,0,1,0,8'hF0, 1, 0));
    vq.push_back(mk(1,1,0,0,0, 0,0,0,0,      1,0,0,0,0,     0, 0));
    vq.push_back(mk(1,1,0,0,0, 1,0,5,0,      1,0,1,0,1,     1, 0));
    vq.push_back(mk(1,0,0,0,0, 1,0,5,0,      0,1,1,0,1,     2, 0));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,      0,0,0,1,16,    1, 1));
    vq.push_back(mk(1,0,0,0,0, 1,0,9,0,      0,1,0,0,0,     0, 1));
    vq.push_back(mk(0,0,0,0,0, 1,1,9,8'hAA,  0,0,0,0,0,     1, 1));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,      0,0,0,0,0,     0, 1));
    vq.push_back(mk(1,1,0,1,0, 0,0,0,0,      1,0,0,0,0,     0, 1));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,1,0,1,0, 0,0,0,0,    1,0,1,0,4,     (i < 3) ? i + 1 : 4, 0));
    vq.push_back(mk(1,1,0,1,0, 1,0,3,0,      0,1,1,0,4,     4, 0));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,      0,0,0,1,10,    1, 1));

    #1;
    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      drive(v.rs, v.q0, v.w0, v.a0, v.d0, v.q1, v.w1, v.a1, v.d1);
      @(negedge clk);
      load_mem = 1'b0;
      chk($sformatf("v%0d gnt0", i), bus.gnt0, v.g0);
      chk($sformatf("v%0d gnt1", i), bus.gnt1, v.g1);
      chk($sformatf("v%0d mem_en", i), bus.mem_en, v.g0 | v.g1);
      chk($sformatf("v%0d rvalid0", i), bus.rvalid0, v.v0);
      chk($sformatf("v%0d rvalid1", i), bus.rvalid1, v.v1);
      if (v.v0 || v.v1) chk($sformatf("v%0d rdata", i), bus.rdata, v.rd);
      if (v.bc >= 0)  chk($sformatf("v%0d burst_cnt", i), dut.burst_cnt, v.bc);
      if (v.own >= 0) chk($sformatf("v%0d owner", i), bus.owner, v.own);
      advance();
    end
    // Write attempted under reset must not have reached the SRAM.
    chk("no write in reset", sram[9], 8'd28);
    chk("loader write", sram[139], 8'hF0);

    // ---------------- randomized phase against the model ----------------
    for (int p = 0; p < 2; p++) new_cmd(p);
    for (int c = 0; c < 800; c++) begin
      int g;
      drive($urandom_range(0, 49) != 0, p_q[0], p_w[0], p_a[0], p_d[0],
            p_q[1], p_w[1], p_a[1], p_d[1]);
      @(negedge clk);
      g = pick(rst, bus.req0, bus.req1);
      chk("r gnt0", bus.gnt0, g == 0);
      chk("r gnt1", bus.gnt1, g == 1);
      chk("r mem_en", bus.mem_en, g >= 0);
      chk("r mem_we", bus.mem_we, (g == 0) ? bus.we0 : (g == 1) ? bus.we1 : 1'b0);
      chk("r mem_addr", bus.mem_addr, (g == 0) ? bus.addr0 : (g == 1) ? bus.addr1 : 8'd0);
      chk("r mem_wdata", bus.mem_wdata, (g == 0) ? bus.wdata0 : (g == 1) ? bus.wdata1 : 8'd0);
      chk("r rvalid0", bus.rvalid0, pend0 && rst);
      chk("r rvalid1", bus.rvalid1, pend1 && rst);
      if ((pend0 || pend1) && rst) chk("r rdata", bus.rdata, pdata);
      chk("r owner", bus.owner, m_own);
      advance();
      for (int p = 0; p < 2; p++)
        if (!p_q[p] || mg == p) new_cmd(p);
    end

    nmis = 0;
    for (int i = 0; i < 256; i++) begin
      er = ref_mem[i];
      if (sram[i] !== er) nmis++;
    end
    chk("final memory image mismatches", nmis, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
